seg_scan_capture: RTL and testbench

//  Receive side of the multiplexed seven-segment display bus. Samples a scanned

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_pattern_to_hex.sv | 46 ++++
 rtl/seg_scan_capture.sv | 153 +++++++++++++++
 tb/tb_seg_scan_capture.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Seven-segment pattern constants {G..A} and scan-capture FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } seg_state_e;

endpackage
`default_nettype wire

// File: rtl/seg_pattern_to_hex.sv
`default_nettype none
// ============================================================================
// Module      : seg_pattern_to_hex
// Description : Combinational seven-segment pattern to hex nibble decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pattern_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       legal_o,
  output logic       blank_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b1;
    blank_o  = 1'b0;
    case (seg_i)
      SEG_HEX_0: nibble_o = 4'h0;
      SEG_HEX_1: nibble_o = 4'h1;
      SEG_HEX_2: nibble_o = 4'h2;
      SEG_HEX_3: nibble_o = 4'h3;
      SEG_HEX_4: nibble_o = 4'h4;
      SEG_HEX_5: nibble_o = 4'h5;
      SEG_HEX_6: nibble_o = 4'h6;
      SEG_HEX_7: nibble_o = 4'h7;
      SEG_HEX_8: nibble_o = 4'h8;
      SEG_HEX_9: nibble_o = 4'h9;
      SEG_HEX_A: nibble_o = 4'hA;
      SEG_HEX_B: nibble_o = 4'hB;
      SEG_HEX_C: nibble_o = 4'hC;
      SEG_HEX_D: nibble_o = 4'hD;
      SEG_HEX_E: nibble_o = 4'hE;
      SEG_HEX_F: nibble_o = 4'hF;
      SEG_BLANK: begin
        legal_o = 1'b0;
        blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_capture
// Description : Samples a scanned seven-segment bus and rebuilds per-digit
//               nibble, dp and validity. Define SEG_ACTIVE_LOW_EN for
//               common-anode (active-low) panels.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic                  dp_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     pattern_err,
  output logic                  anode_err,
  output logic                  frame_done
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam int              SW      = DIGITS + 8;
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  logic [SW-1:0]       w_raw;
  logic [SW-1:0]       sync1_q, samp_q, prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  seg_state_e          state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   dp_q, dp_d, valid_q, valid_d, perr_q, perr_d;
  logic [DIGITS-1:0]   seen_q, seen_d, w_cap_hit;
  logic                aerr_q, aerr_d, fdone_q, fdone_d;

`ifdef SEG_ACTIVE_LOW_EN
  assign w_raw = ~{an_in, seg_in, dp_in};
`else
  assign w_raw = {an_in, seg_in, dp_in};
`endif

  logic              w_changed;
  logic [DIGITS-1:0] w_an;
  logic [DIGITS-1:0] w_cap_an;
  logic [6:0]        w_cap_seg;
  logic              w_cap_dp;
  logic              w_onehot;
  logic [3:0]        w_nibble;
  logic              w_legal, w_blank;

  assign w_changed = (samp_q != prev_q);
  assign w_an      = samp_q[SW-1 -: DIGITS];
  // prev_q holds the value that just proved stable, even if S moves in CAPTURE
  assign w_cap_an  = prev_q[SW-1 -: DIGITS];
  assign w_cap_seg = prev_q[7:1];
  assign w_cap_dp  = prev_q[0];
  assign w_onehot  = $onehot(w_cap_an);

  seg_pattern_to_hex u_dec (
    .seg_i    (w_cap_seg),
    .nibble_o (w_nibble),
    .legal_o  (w_legal),
    .blank_o  (w_blank)
  );

  always_comb begin
    cnt_d   = w_changed ? CW'(1) : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1));
    state_d = state_q;
    if (w_an == '0)
      state_d = IDLE;
    else if ((state_q == CAPTURE || state_q == HOLD) && !w_changed)
      state_d = HOLD;
    else if (cnt_d == CNT_MAX)
      state_d = CAPTURE;
    else
      state_d = SETTLE;
  end

  always_comb begin
    digits_d  = digits_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    w_cap_hit = '0;
    if (state_q == CAPTURE && w_onehot) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (w_cap_an[i]) begin
          w_cap_hit[i] = 1'b1;
          dp_d[i]      = w_cap_dp;
          if (w_legal) begin
            digits_d[4*i +: 4] = w_nibble;
            valid_d[i]         = 1'b1;
            perr_d[i]          = 1'b0;
          end else if (w_blank) begin
            valid_d[i] = 1'b0;
            perr_d[i]  = 1'b0;
          end else begin
            digits_d[4*i +: 4] = 4'h0;
            valid_d[i]         = 1'b0;
            perr_d[i]          = 1'b1;
          end
        end
      end
    end
    aerr_d  = (state_q == CAPTURE) && !w_onehot && (w_cap_an != '0);
    fdone_d = &seen_q;
    seen_d  = ((&seen_q) ? '0 : seen_q) | w_cap_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      samp_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      digits_q <= '0;
      dp_q     <= '0;
      valid_q  <= '0;
      perr_q   <= '0;
      seen_q   <= '0;
      aerr_q   <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      sync1_q  <= w_raw;
      samp_q   <= sync1_q;
      prev_q   <= samp_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      seen_q   <= seen_d;
      aerr_q   <= aerr_d;
      fdone_q  <= fdone_d;
    end
  end

  assign digits_out  = digits_q;
  assign dp_out      = dp_q;
  assign digit_valid = valid_q;
  assign pattern_err = perr_q;
  assign anode_err   = aerr_q;
  assign frame_done  = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_capture
// Description : Scoreboard bench for seg_scan_capture (DIGITS=4, STABLE=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_capture;

  localparam int DIGITS        = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int LAT           = 2 + STABLE_CYCLES + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h00;
  logic        dp_in = 1'b0;
  logic [3:0]  an_in = 4'h0;
  logic [15:0] digits_out;
  logic [3:0]  dp_out, digit_valid, pattern_err;
  logic        anode_err, frame_done;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  val;
    logic [3:0]  perr;
    logic        aerr;
    logic        fdone;
    logic [31:0] cyc;
  } snap_t;

  snap_t       exp_q[$];
  string       exp_nm[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n;
  bit          mon_en = 1'b0;
  logic [27:0] last_data;
  logic [27:0] mon_cur;
  snap_t       mon_e;
  string       mon_nm;

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dp_in       (dp_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .dp_out      (dp_out),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
    .anode_err   (anode_err),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input string nm, input logic [15:0] dig, input logic [3:0] dp,
                           input logic [3:0] val, input logic [3:0] perr,
                           input logic aerr, input logic fdone, input int c);
    snap_t s;
    s.dig = dig; s.dp = dp; s.val = val; s.perr = perr;
    s.aerr = aerr; s.fdone = fdone; s.cyc = 32'(c);
    exp_q.push_back(s);
    exp_nm.push_back(nm);
  endtask

  task automatic apply(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int hold);
    an_in = an; seg_in = seg; dp_in = dp;
    repeat (hold) @(posedge clk);
    #2;
  endtask

  // Monitor: any change in digit state, or any pulse, is an output event
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {digits_out, dp_out, digit_valid, pattern_err};
      if (mon_cur !== last_data || anode_err !== 1'b0 || frame_done !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got dig=%h dp=%b val=%b perr=%b aerr=%b fdone=%b at cyc=%0d, required no event",
                   digits_out, dp_out, digit_valid, pattern_err, anode_err, frame_done, cyc);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_nm = exp_nm.pop_front();
          if (digits_out !== mon_e.dig || dp_out !== mon_e.dp || digit_valid !== mon_e.val ||
              pattern_err !== mon_e.perr || anode_err !== mon_e.aerr ||
              frame_done !== mon_e.fdone || 32'(cyc) != mon_e.cyc) begin
            errors++;
            $display("FAIL %s: got dig=%h dp=%b val=%b perr=%b aerr=%b fdone=%b cyc=%0d, required dig=%h dp=%b val=%b perr=%b aerr=%b fdone=%b cyc=%0d",
                     mon_nm, digits_out, dp_out, digit_valid, pattern_err, anode_err, frame_done, cyc,
                     mon_e.dig, mon_e.dp, mon_e.val, mon_e.perr, mon_e.aerr, mon_e.fdone, mon_e.cyc);
          end
        end
      end
      last_data = mon_cur;
    end
  end

  logic [6:0]  scan_pat [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
  logic [15:0] scan_dig [4] = '{16'h0000, 16'h0010, 16'h0210, 16'h3210};
  logic [3:0]  scan_val [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({digits_out, dp_out, digit_valid, pattern_err, anode_err, frame_done} !== 30'h0) begin
      errors++;
      $display("FAIL reset_state: got %h, required 0",
               {digits_out, dp_out, digit_valid, pattern_err, anode_err, frame_done});
    end
    last_data = {digits_out, dp_out, digit_valid, pattern_err};
    mon_en = 1'b1;
    @(posedge clk); #2;

    // 1: single digit capture
    n = cyc;
    expect_ev("t1_digit0", 16'h0002, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, n + LAT);
    apply(4'b0001, 7'h5B, 1'b1, 12);
    apply(4'b0000, 7'h00, 1'b0, 6);

    // 2: full scan, one frame_done after the last digit
    for (int k = 0; k < 4; k++) begin
      n = cyc;
      expect_ev($sformatf("t2_digit%0d", k), scan_dig[k], 4'b0000, scan_val[k], 4'b0000, 1'b0, 1'b0, n + LAT);
      if (k == 3)
        expect_ev("t2_frame_done", 16'h3210, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1, n + LAT + 1);
      apply(4'(1 << k), scan_pat[k], 1'b0, 12);
    end
    apply(4'b0000, 7'h00, 1'b0, 6);

    // 3: toggling segments never settle, then 8 is captured
    apply(4'b0001, 7'h06, 1'b0, 4);
    apply(4'b0001, 7'h07, 1'b0, 4);
    apply(4'b0001, 7'h06, 1'b0, 4);
    apply(4'b0001, 7'h07, 1'b0, 4);
    n = cyc;
    expect_ev("t3_settled", 16'h3218, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, n + LAT);
    apply(4'b0001, 7'h7F, 1'b0, 12);
    apply(4'b0000, 7'h00, 1'b0, 6);

    // 4: non-one-hot anode
    n = cyc;
    expect_ev("t4_anode_err", 16'h3218, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, n + LAT);
    apply(4'b0110, 7'h3F, 1'b0, 12);
    apply(4'b0000, 7'h00, 1'b0, 6);

    // 5: unknown pattern
    n = cyc;
    expect_ev("t5_pattern_err", 16'h3018, 4'b0000, 4'b1011, 4'b0100, 1'b0, 1'b0, n + LAT);
    apply(4'b0100, 7'h2A, 1'b0, 12);
    apply(4'b0000, 7'h00, 1'b0, 6);

    // blank digit keeps its nibble, takes dp
    n = cyc;
    expect_ev("t7_blank", 16'h3018, 4'b0001, 4'b1010, 4'b0100, 1'b0, 1'b0, n + LAT);
    apply(4'b0001, 7'h00, 1'b1, 12);
    apply(4'b0000, 7'h00, 1'b0, 6);

    // 6: reset at count=5 discards the window, re-capture after full latency
    apply(4'b1000, 7'h6F, 1'b1, 6);
    n = cyc;
    expect_ev("t6_reset", 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, n + 1);
    expect_ev("t6_recapture", 16'h9000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, n + 1 + LAT);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;

    for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
